// File: rtl/toggle_meter_pkg.sv
// Shared types and helpers for the toggle_meter block.
package toggle_meter_pkg;

  typedef enum logic [1:0] {IDLE, SEEK, HIGH, LOW} state_t;

  // Without duty measurement, HIGH doubles as the single counting state.
  localparam state_t COUNT = HIGH;

  localparam int CNT_W_DEF = 16;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/toggle_meter_sync_edge_det.sv
// Input synchronizer chain plus one delay flop for rise/fall detection.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d_in};
      level_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~level_d;
  assign fall  = ~level & level_d;

endmodule

// File: rtl/toggle_meter.sv
// Measures period and high time of a toggling input; results on a valid/ready port.
// Build option TOGGLE_METER_DUTY_EN: defined -> high time measured, else high_out is 0.
//
// state | meaning
// IDLE  | measurement disabled, counters cleared
// SEEK  | waiting for the first rise of a measurement
// HIGH  | input high, counting (also the merged COUNT state without duty)
// LOW   | input low, counting; next rise captures the period
module toggle_meter
  import toggle_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  output logic             stalled
);

  localparam logic [31:0]      CNT_MAX  = 32'({CNT_W{1'b1}});
  localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic             capture, stall_set, stall_clr;
  logic             rise, fall, level_unused;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (sig_in),
    .level (level_unused),
    .rise  (rise),
    .fall  (fall)
  );

  assign cnt_inc = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));

`ifdef TOGGLE_METER_DUTY_EN
  logic [CNT_W-1:0] hold_q, hold_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    capture   = 1'b0;
    stall_set = 1'b0;
    stall_clr = 1'b0;
`ifdef TOGGLE_METER_DUTY_EN
    hold_d    = hold_q;
`endif
    if (!meas_en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      tmr_d     = TMR_LOAD;
      stall_clr = 1'b1;
    end else begin
      // Idle timer: reloaded on any edge, runs down while measuring.
      if (state_q == IDLE || rise || fall)
        tmr_d = TMR_LOAD;
      else if (tmr_q != '0)
        tmr_d = tmr_q - 1'b1;
      if (rise)
        stall_clr = 1'b1;
      case (state_q)
        IDLE: state_d = SEEK;
        SEEK: begin
          if (rise) begin
            cnt_d   = CNT_W'(1);
            state_d = HIGH;
          end
        end
`ifdef TOGGLE_METER_DUTY_EN
        HIGH: begin
          cnt_d = cnt_inc;
          if (fall) begin
            hold_d  = cnt_q;
            state_d = LOW;
          end
        end
        LOW: begin
          cnt_d = cnt_inc;
          if (rise) begin
            capture = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = HIGH;
          end
        end
`else
        COUNT: begin
          cnt_d = cnt_inc;
          if (rise) begin
            capture = 1'b1;
            cnt_d   = CNT_W'(1);
          end
        end
`endif
        default: state_d = IDLE;
      endcase
      if (state_q != IDLE && !rise && !fall && tmr_q == '0) begin
        stall_set = 1'b1;
        state_d   = SEEK;
        cnt_d     = '0;
        tmr_d     = TMR_LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmr_q   <= TMR_LOAD;
`ifdef TOGGLE_METER_DUTY_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
`ifdef TOGGLE_METER_DUTY_EN
      hold_q  <= hold_d;
`endif
    end
  end

  // A capture loads only when the slot is free or being accepted this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_out <= '0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
      stalled    <= 1'b0;
`ifdef TOGGLE_METER_DUTY_EN
      high_out   <= '0;
`endif
    end else begin
      if (capture && (!valid || ready)) begin
        period_out <= cnt_q;
`ifdef TOGGLE_METER_DUTY_EN
        high_out   <= hold_q;
`endif
        valid      <= 1'b1;
      end else if (capture) begin
        overrun <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (stall_set)
        stalled <= 1'b1;
      else if (stall_clr)
        stalled <= 1'b0;
    end
  end

`ifndef TOGGLE_METER_DUTY_EN
  assign high_out = '0;
`endif

endmodule

// File: tb/tb_toggle_meter.sv
// Self-checking bench for toggle_meter: vector table, directed corner cases, random waves.
module tb_toggle_meter;

  localparam int CNT_W       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 100;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sig_in = 1'b0;
  logic             meas_en = 1'b0;
  logic             ready = 1'b0;
  logic [CNT_W-1:0] period_out, high_out;
  logic             valid, overrun, stalled;

  toggle_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .meas_en    (meas_en),
    .period_out (period_out),
    .high_out   (high_out),
    .valid      (valid),
    .ready      (ready),
    .overrun    (overrun),
    .stalled    (stalled)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int p; int h; } res_t;
  typedef struct { int h; int l; int n; int ep; int eh; } vec_t;

  res_t acc_q[$];
  res_t exp_q[$];
  int   valid_cycles = 0;
  int   total = 0;
  int   bad = 0;
  int   last_rise = -1;
  int   last_fall = 0;

  // Accepted results, seen on the falling edge before the accepting rising edge.
  always @(negedge clk) begin
    if (valid) valid_cycles++;
    if (valid && ready) acc_q.push_back('{int'(period_out), int'(high_out)});
  end

  function automatic int exp_h(int h);
`ifdef TOGGLE_METER_DUTY_EN
    return h;
`else
    return 0;
`endif
  endfunction

  task automatic check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Reference model: each rise after the first of a session reports the
  // rise-to-rise distance and the preceding high time.
  task automatic set_sig(bit v);
    sig_in = v;
    if (v) begin
      if (last_rise >= 0) exp_q.push_back('{cyc - last_rise, exp_h(last_fall - last_rise)});
      last_rise = cyc;
    end else begin
      last_fall = cyc;
    end
  endtask

  task automatic wave(int h, int l, int n);
    for (int k = 0; k < n; k++) begin
      set_sig(1'b1);
      tick(h);
      set_sig(1'b0);
      tick(l);
    end
  endtask

  task automatic session_start();
    meas_en = 1'b0;
    tick(2);
    meas_en = 1'b1;
    tick(3);
    last_rise = -1;
    acc_q.delete();
    exp_q.delete();
    valid_cycles = 0;
  endtask

  task automatic check_zero_outputs(string name);
    check({name, " period"}, int'(period_out), 0);
    check({name, " high"}, int'(high_out), 0);
    check({name, " valid"}, int'(valid), 0);
    check({name, " overrun"}, int'(overrun), 0);
    check({name, " stalled"}, int'(stalled), 0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{11, 11, 4, 22, 11};
    vecs[1] = '{5, 15, 3, 20, 5};
    vecs[2] = '{1, 1, 5, 2, 1};
    vecs[3] = '{3, 7, 4, 10, 3};
    vecs[4] = '{30, 2, 3, 32, 30};
    vecs[5] = '{40, 40, 3, 80, 40};

    tick(2);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    ready = 1'b1;
    tick(2);

    // Table-driven waves with ready held high.
    for (int v = 0; v < 6; v++) begin
      session_start();
      wave(vecs[v].h, vecs[v].l, vecs[v].n);
      tick(4);
      check($sformatf("vec%0d count", v), acc_q.size(), vecs[v].n - 1);
      check($sformatf("vec%0d valid_cycles", v), valid_cycles, vecs[v].n - 1);
      for (int i = 0; i < acc_q.size() && i < vecs[v].n - 1; i++) begin
        check($sformatf("vec%0d[%0d] period", v, i), acc_q[i].p, vecs[v].ep);
        check($sformatf("vec%0d[%0d] high", v, i), acc_q[i].h, exp_h(vecs[v].eh));
      end
      check($sformatf("vec%0d overrun", v), int'(overrun), 0);
    end

    // Random waves against the reference model.
    session_start();
    for (int k = 0; k < 15; k++) wave($urandom_range(1, 40), $urandom_range(1, 40), 1);
    tick(4);
    check("rand count", acc_q.size(), exp_q.size());
    for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("rand[%0d] period", i), acc_q[i].p, exp_q[i].p);
      check($sformatf("rand[%0d] high", i), acc_q[i].h, exp_q[i].h);
    end
    check("rand overrun", int'(overrun), 0);

    // Timeout: stall asserts TIMEOUT cycles after the last detected edge.
    session_start();
    set_sig(1'b1);
    tick(5);
    set_sig(1'b0);
    tick(TIMEOUT + SYNC_STAGES);
    check("stall early", int'(stalled), 0);
    tick(1);
    check("stall set", int'(stalled), 1);
    tick(150 - TIMEOUT - SYNC_STAGES - 1);
    set_sig(1'b1);
    tick(SYNC_STAGES);
    check("stall before rise", int'(stalled), 1);
    tick(1);
    check("stall cleared", int'(stalled), 0);
    tick(5 - SYNC_STAGES - 1);
    set_sig(1'b0);
    tick(15);
    check("stall first rise no capture", acc_q.size(), 0);
    wave(5, 15, 1);
    tick(4);
    check("stall count", acc_q.size(), 1);
    if (acc_q.size() > 0) check("stall period", acc_q[0].p, 20);

    // Overrun: ready low across three captures.
    session_start();
    ready = 1'b0;
    wave(11, 11, 3);
    set_sig(1'b1);
    tick(11);
    set_sig(1'b0);
    tick(5);
    check("ovr valid", int'(valid), 1);
    check("ovr overrun", int'(overrun), 1);
    check("ovr period held", int'(period_out), 22);
    check("ovr high held", int'(high_out), exp_h(11));
    ready = 1'b1;
    tick(1);
    check("ovr accept drops valid", int'(valid), 0);
    tick(5);
    wave(11, 11, 2);
    tick(4);
    check("ovr count", acc_q.size(), 3);
    for (int i = 0; i < acc_q.size() && i < 3; i++)
      check($sformatf("ovr[%0d] period", i), acc_q[i].p, 22);

    // Asynchronous reset mid-HIGH with a pending result.
    session_start();
    ready = 1'b0;
    wave(11, 11, 3);
    set_sig(1'b1);
    tick(6);
    check("pre-reset valid", int'(valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async reset");
    sig_in = 1'b0;
    tick(3);
    rst_n = 1'b1;
    ready = 1'b1;
    acc_q.delete();
    last_rise = -1;
    tick(4);
    wave(11, 11, 1);
    check("post-reset one rise", acc_q.size(), 0);
    wave(11, 11, 1);
    tick(4);
    check("post-reset count", acc_q.size(), 1);
    if (acc_q.size() > 0) check("post-reset period", acc_q[0].p, 22);

    // meas_en drop mid-LOW keeps the pending result and discards the partial count.
    ready = 1'b0;
    session_start();
    wave(11, 11, 1);
    set_sig(1'b1);
    tick(11);
    set_sig(1'b0);
    tick(4);
    meas_en = 1'b0;
    tick(3);
    check("en-drop valid", int'(valid), 1);
    check("en-drop period", int'(period_out), 22);
    check("en-drop high", int'(high_out), exp_h(11));
    meas_en = 1'b1;
    ready = 1'b1;
    acc_q.delete();
    tick(7);
    wave(5, 15, 2);
    tick(4);
    check("en-drop count", acc_q.size(), 2);
    if (acc_q.size() >= 2) begin
      check("en-drop old period", acc_q[0].p, 22);
      check("en-drop old high", acc_q[0].h, exp_h(11));
      check("en-drop new period", acc_q[1].p, 20);
      check("en-drop new high", acc_q[1].h, exp_h(5));
    end
    check("en-drop overrun", int'(overrun), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
